// File: rtl/store_lane_formatter.sv
// Store lane formatter: narrows a register value into the byte lanes of a
// word-aligned data-memory write and runs the req/ack write handshake.
module store_lane_formatter #(
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  st_err_code,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] E_MISAL = 2'b01;
  localparam logic [1:0] E_SIZE  = 2'b10;
  localparam logic [1:0] E_TMO   = 2'b11;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [1:0]  code;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        illegal;
  logic        misal;
  logic        accept;

  assign st_ready    = (state == S_IDLE);
  assign mem_req     = (state == S_REQ);
  assign st_done     = (state == S_FIN);
  assign st_err      = (state == S_ERR);
  assign st_err_code = code;
  assign accept      = st_valid && st_ready;

  assign illegal = (st_size == 2'b11);
  assign misal   = ((st_size == 2'b01) && st_addr[0])
                || ((st_size == 2'b10) && (st_addr[1:0] != 2'b00));

  // Data is the same for both lane orders; only the enables move.
  always_comb begin
    lane_data = '0;
    lane_be   = '0;
    unique case (1'b1)
      (st_size == 2'b00): begin
        lane_data = {4{st_data[7:0]}};
        lane_be   = BIG_ENDIAN ? (4'b1000 >> st_addr[1:0])
                               : (4'b0001 << st_addr[1:0]);
      end
      (st_size == 2'b01): begin
        lane_data = {2{st_data[15:0]}};
        if (BIG_ENDIAN)
          lane_be = st_addr[1] ? 4'b0011 : 4'b1100;
        else
          lane_be = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      (st_size == 2'b10): begin
        lane_data = st_data;
        lane_be   = 4'b1111;
      end
      default: begin
        lane_data = '0;
        lane_be   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      code      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (illegal) begin
              state <= S_ERR;
              code  <= E_SIZE;
            end else if (misal) begin
              state <= S_ERR;
              code  <= E_MISAL;
            end else begin
              state     <= S_REQ;
              code      <= '0;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= lane_data;
              mem_be    <= lane_be;
            end
          end
        end
        S_REQ: begin
          // Ack in the last allowed cycle still completes the write.
          if (mem_ack) begin
            state  <= S_FIN;
            cnt    <= '0;
            mem_be <= '0;
          end else if (cnt == LAST) begin
            state  <= S_ERR;
            code   <= E_TMO;
            cnt    <= '0;
            mem_be <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_lane_formatter.sv
// Bench for store_lane_formatter: LE and BE instances share stimulus,
// a scoreboard queue is drained by a negedge monitor.
module tb_store_lane_formatter;

  localparam int TO = 4;

  typedef struct {
    logic        done;
    logic [1:0]  code;
    int          reqs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bel;
    logic [3:0]  beb;
  } exp_t;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        st_valid = 0;
  logic [1:0]  st_size = 0;
  logic [31:0] st_addr = 0;
  logic [31:0] st_data = 0;
  logic        mem_ack = 0;

  logic        ready_l, done_l, err_l, req_l;
  logic [1:0]  code_l;
  logic [31:0] addr_l, wdata_l;
  logic [3:0]  be_l;
  logic        ready_b, done_b, err_b, req_b;
  logic [1:0]  code_b;
  logic [31:0] addr_b, wdata_b;
  logic [3:0]  be_b;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int          req_n = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_bel, cap_beb;

  always #5 clk = ~clk;

  store_lane_formatter #(.BIG_ENDIAN(1'b0), .TIMEOUT(TO)) dut_le (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(ready_l),
    .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .st_done(done_l), .st_err(err_l), .st_err_code(code_l),
    .mem_req(req_l), .mem_ack(mem_ack),
    .mem_addr(addr_l), .mem_wdata(wdata_l), .mem_be(be_l)
  );

  store_lane_formatter #(.BIG_ENDIAN(1'b1), .TIMEOUT(TO)) dut_be (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(ready_b),
    .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .st_done(done_b), .st_err(err_b), .st_err_code(code_b),
    .mem_req(req_b), .mem_ack(mem_ack),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_be(be_b)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  // Monitor: capture the write while mem_req is up, check on each pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      req_n = 0;
    end else begin
      if (req_l) begin
        if (req_n == 0) begin
          cap_addr  = addr_l;
          cap_wdata = wdata_l;
          cap_bel   = be_l;
          cap_beb   = be_b;
        end else begin
          chk("stable_addr", addr_l, cap_addr);
          chk("stable_wdata", wdata_l, cap_wdata);
          chk("stable_be", {28'd0, be_l}, {28'd0, cap_bel});
        end
        req_n++;
      end
      if (done_l || err_l) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_pulse done=%b err=%b", done_l, err_l);
        end else begin
          automatic exp_t e = exp_q.pop_front();
          chk("done_le", {31'd0, done_l}, {31'd0, e.done});
          chk("err_le", {31'd0, err_l}, {31'd0, !e.done});
          chk("done_be", {31'd0, done_b}, {31'd0, e.done});
          chk("req_cycles", req_n, e.reqs);
          if (!e.done) begin
            chk("code_le", {30'd0, code_l}, {30'd0, e.code});
            chk("code_be", {30'd0, code_b}, {30'd0, e.code});
          end
          if (e.reqs > 0) begin
            chk("mem_addr", cap_addr, e.addr);
            chk("mem_wdata", cap_wdata, e.wdata);
            chk("be_le", {28'd0, cap_bel}, {28'd0, e.bel});
            chk("be_be", {28'd0, cap_beb}, {28'd0, e.beb});
          end
          chk("fin_be_zero", {28'd0, be_l}, 32'd0);
        end
        req_n = 0;
      end
    end
  end

  task automatic send(logic [1:0] sz, logic [31:0] a, logic [31:0] d,
                      int ack_at, exp_t e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    st_valid = 1; st_size = sz; st_addr = a; st_data = d;
    @(posedge clk); #1;
    st_valid = 0;
    if (e.reqs > 0) begin
      for (int i = 1; i <= TO; i++) begin
        if (i == ack_at) mem_ack = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        if (i == ack_at) break;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  function automatic exp_t ok(int reqs, logic [31:0] a, logic [31:0] w,
                              logic [3:0] bl, logic [3:0] bb);
    exp_t e;
    e.done = 1; e.code = 2'b00; e.reqs = reqs;
    e.addr = a; e.wdata = w; e.bel = bl; e.beb = bb;
    return e;
  endfunction

  function automatic exp_t bad(logic [1:0] c, int reqs, logic [31:0] a,
                               logic [31:0] w, logic [3:0] bl,
                               logic [3:0] bb);
    exp_t e;
    e.done = 0; e.code = c; e.reqs = reqs;
    e.addr = a; e.wdata = w; e.bel = bl; e.beb = bb;
    return e;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready_l}, 32'd1);
    chk("rst_ready_be", {31'd0, ready_b}, 32'd1);
    chk("rst_req", {31'd0, req_l}, 32'd0);
    chk("rst_done", {31'd0, done_l}, 32'd0);
    chk("rst_err", {31'd0, err_l}, 32'd0);
    chk("rst_code", {30'd0, code_l}, 32'd0);
    chk("rst_addr", addr_l, 32'd0);
    chk("rst_wdata", wdata_l, 32'd0);
    chk("rst_be", {28'd0, be_l}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_req", {31'd0, req_l}, 32'd0);
    end

    send(2'b00, 32'h0000_1003, 32'hDEAD_BEEF, 2,
         ok(2, 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000, 4'b0001));
    send(2'b01, 32'h0000_0002, 32'h1234_5678, 1,
         ok(1, 32'h0000_0000, 32'h5678_5678, 4'b1100, 4'b0011));
    send(2'b10, 32'h0000_0000, 32'h1234_5678, 1,
         ok(1, 32'h0000_0000, 32'h1234_5678, 4'b1111, 4'b1111));
    send(2'b01, 32'h0000_0001, 32'h1234_5678, 0,
         bad(2'b01, 0, 0, 0, 0, 0));
    send(2'b10, 32'h0000_0006, 32'h1234_5678, 0,
         bad(2'b01, 0, 0, 0, 0, 0));
    send(2'b11, 32'h0000_0001, 32'h1234_5678, 0,
         bad(2'b10, 0, 0, 0, 0, 0));
    send(2'b00, 32'h0000_0000, 32'h0000_00A5, 0,
         bad(2'b11, TO, 32'h0, 32'hA5A5_A5A5, 4'b0001, 4'b1000));
    @(negedge clk);
    chk("code_held", {30'd0, code_l}, 32'd3);
    chk("ready_after_tmo", {31'd0, ready_l}, 32'd1);
    send(2'b10, 32'h0000_0004, 32'hCAFE_F00D, TO,
         ok(TO, 32'h0000_0004, 32'hCAFE_F00D, 4'b1111, 4'b1111));
    send(2'b00, 32'hFFFF_FFFF, 32'h1122_3344, 1,
         ok(1, 32'hFFFF_FFFC, 32'h4444_4444, 4'b1000, 4'b0001));
    send(2'b01, 32'h0000_0000, 32'hFFFF_1234, 3,
         ok(3, 32'h0000_0000, 32'h1234_1234, 4'b0011, 4'b1100));

    @(posedge clk); #1;
    st_valid = 1; st_size = 2'b00; st_addr = 32'h5; st_data = 32'h77;
    @(posedge clk); #1;
    st_valid = 0;
    @(negedge clk);
    chk("req_before_rst", {31'd0, req_l}, 32'd1);
    reset_n = 0;
    @(negedge clk);
    chk("req_after_rst", {31'd0, req_l}, 32'd0);
    chk("done_after_rst", {31'd0, done_l}, 32'd0);
    chk("err_after_rst", {31'd0, err_l}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    repeat (2) @(posedge clk);
    send(2'b00, 32'h0000_0006, 32'h0000_00AB, 1,
         ok(1, 32'h0000_0004, 32'hABAB_ABAB, 4'b0100, 4'b0010));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
